// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RV32I pipeline, between ex_mem and mem_wb.
//   Non-memory ops pass through with zero added latency. Loads and stores
//   hold a level request to the memory controller and stall the pipeline
//   until the access completes. Load data is sign- or zero-extended here.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rdy               global ready; low freezes all state
//   ex_*              instruction fields from ex_mem (held stable while stalled)
//   mem_rd_*          writeback fields to mem_wb
//   mem_stall         pipeline hold while an access is outstanding
//   mc_req/we/addr/len/wdata   request to the memory controller
//   mc_done, mc_rdata          completion pulse and right-aligned read data
//
// state | meaning
// IDLE  | evaluate incoming op; pass through or issue a request
// BUSY  | request outstanding, waiting for mc_done
// DONE  | access complete; hand result to mem_wb, then return to IDLE
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [DATA_W-1:0] ex_rd_data,
  input  logic [4:0]        ex_rd_addr,
  input  logic              ex_rd_enable,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic [4:0]        mem_rd_addr,
  output logic              mem_rd_enable,
  output logic              mem_stall,
  output logic              mc_req,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [1:0]        mc_len,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_rdata
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_result;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic [1:0]        w_len;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_val;
  logic              w_req;

  // Op decode; unused codes 9-15 fall into the NONE default.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_len      = 2'd0;
    w_load_val = '0;
    case (ex_mem_op)
      OP_LB:  begin w_is_load = 1'b1;  w_len = 2'd0;
                    w_load_val = {{(DATA_W-8){mc_rdata[7]}}, mc_rdata[7:0]}; end
      OP_LBU: begin w_is_load = 1'b1;  w_len = 2'd0;
                    w_load_val = {{(DATA_W-8){1'b0}}, mc_rdata[7:0]}; end
      OP_LH:  begin w_is_load = 1'b1;  w_len = 2'd1;
                    w_load_val = {{(DATA_W-16){mc_rdata[15]}}, mc_rdata[15:0]}; end
      OP_LHU: begin w_is_load = 1'b1;  w_len = 2'd1;
                    w_load_val = {{(DATA_W-16){1'b0}}, mc_rdata[15:0]}; end
      OP_LW:  begin w_is_load = 1'b1;  w_len = 2'd3;
                    w_load_val = mc_rdata; end
      OP_SB:  begin w_is_store = 1'b1; w_len = 2'd0; end
      OP_SH:  begin w_is_store = 1'b1; w_len = 2'd1; end
      OP_SW:  begin w_is_store = 1'b1; w_len = 2'd3; end
      default: ;
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;

  always_comb begin
    case (w_len)
      2'd0:    w_wdata = {{(DATA_W-8){1'b0}}, ex_mem_wdata[7:0]};
      2'd1:    w_wdata = {{(DATA_W-16){1'b0}}, ex_mem_wdata[15:0]};
      default: w_wdata = ex_mem_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
    end else if (rdy) begin
      case (r_state)
        IDLE: if (w_is_mem) r_state <= BUSY;
        BUSY: if (mc_done) begin
          r_result <= w_load_val;  // stores decode to 0
          r_state  <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request is raised in the arrival cycle so the access starts without
  // waiting a cycle for the FSM to reach BUSY.
  assign w_req = ((r_state == IDLE) && w_is_mem) || (r_state == BUSY);

  assign mc_req    = w_req;
  assign mem_stall = w_req;
  assign mc_we     = w_is_store;
  assign mc_addr   = ex_mem_addr;
  assign mc_len    = w_len;
  assign mc_wdata  = w_wdata;

  assign mem_rd_addr = ex_rd_addr;

  always_comb begin
    mem_rd_data   = ex_rd_data;
    mem_rd_enable = ex_rd_enable & ~w_req;
    if (r_state == DONE) begin
      mem_rd_enable = ex_rd_enable & w_is_load;
      if (w_is_load) mem_rd_data = r_result;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of load/store accesses plus
// hand-written sequences for reset, rdy freeze and stray mc_done pulses.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] ex_rd_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_enable;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_wdata;
  logic [31:0] mem_rd_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_enable;
  logic        mem_stall;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [1:0]  mc_len;
  logic [31:0] mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_enable(ex_rd_enable),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
    .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
    .mem_stall(mem_stall), .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr),
    .mc_len(mc_len), .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;          // cycle in which mc_done arrives
    logic [31:0] exp_data;   // load result (unused for stores)
    logic        exp_en;
    logic [1:0]  exp_len;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] exd;
    exd = 32'hC0FFEE00 + idx;
    @(posedge clk); #1;
    ex_mem_op = v.op; ex_mem_addr = v.addr; ex_mem_wdata = v.wdata;
    ex_rd_data = exd; ex_rd_addr = 5'(idx + 1); ex_rd_enable = 1'b1;
    mc_done = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d c0 req", idx),   32'(mc_req), 32'd1);
    check($sformatf("v%0d c0 stall", idx), 32'(mem_stall), 32'd1);
    check($sformatf("v%0d we", idx),       32'(mc_we), 32'(v.exp_we));
    check($sformatf("v%0d len", idx),      32'(mc_len), 32'(v.exp_len));
    check($sformatf("v%0d addr", idx),     mc_addr, v.addr);
    check($sformatf("v%0d wdata", idx),    mc_wdata, v.exp_wdata);
    for (int c = 1; c <= v.k; c++) begin
      @(posedge clk); #1;
      if (c == v.k) begin mc_done = 1'b1; mc_rdata = v.rdata; end
      else          mc_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check($sformatf("v%0d c%0d stall", idx, c), 32'(mem_stall), 32'd1);
      check($sformatf("v%0d c%0d req", idx, c),   32'(mc_req), 32'd1);
    end
    @(posedge clk); #1;
    mc_done = 1'b0; mc_rdata = 32'h0;
    @(negedge clk);
    check($sformatf("v%0d done stall", idx), 32'(mem_stall), 32'd0);
    check($sformatf("v%0d done req", idx),   32'(mc_req), 32'd0);
    check($sformatf("v%0d done data", idx),  mem_rd_data, v.exp_en ? v.exp_data : exd);
    check($sformatf("v%0d done en", idx),    32'(mem_rd_enable), 32'(v.exp_en));
    check($sformatf("v%0d done rd", idx),    32'(mem_rd_addr), 32'(idx + 1));
    @(posedge clk); #1;
    ex_mem_op = 4'd0; ex_rd_data = 32'h600D0000 + idx;
    @(negedge clk);
    check($sformatf("v%0d next req", idx),   32'(mc_req), 32'd0);
    check($sformatf("v%0d next stall", idx), 32'(mem_stall), 32'd0);
    check($sformatf("v%0d next data", idx),  mem_rd_data, 32'h600D0000 + idx);
  endtask

  initial begin
    vecs[0] = '{4'd1, 32'h100, 32'h12345678, 32'h000000F0, 3, 32'hFFFFFFF0, 1'b1, 2'd0, 1'b0, 32'h00000078};
    vecs[1] = '{4'd5, 32'h104, 32'h12345678, 32'h0000F00D, 1, 32'h0000F00D, 1'b1, 2'd1, 1'b0, 32'h00005678};
    vecs[2] = '{4'd2, 32'h106, 32'h12345678, 32'h00008001, 2, 32'hFFFF8001, 1'b1, 2'd1, 1'b0, 32'h00005678};
    vecs[3] = '{4'd3, 32'h108, 32'h12345678, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b1, 2'd3, 1'b0, 32'h12345678};
    vecs[4] = '{4'd4, 32'h10B, 32'h0, 32'h123456F0, 2, 32'h000000F0, 1'b1, 2'd0, 1'b0, 32'h00000000};
    vecs[5] = '{4'd6, 32'h020, 32'hAABBCCDD, 32'h0, 1, 32'h0, 1'b0, 2'd0, 1'b1, 32'h000000DD};
    vecs[6] = '{4'd7, 32'h022, 32'hAABBCCDD, 32'h0, 2, 32'h0, 1'b0, 2'd1, 1'b1, 32'h0000CCDD};
    vecs[7] = '{4'd8, 32'h024, 32'hAABBCCDD, 32'h0, 1, 32'h0, 1'b0, 2'd3, 1'b1, 32'hAABBCCDD};

    rst = 1'b1; rdy = 1'b1;
    ex_rd_data = '0; ex_rd_addr = '0; ex_rd_enable = 1'b0;
    ex_mem_op = '0; ex_mem_addr = '0; ex_mem_wdata = '0;
    mc_done = 1'b0; mc_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ex_rd_data = 32'h1234; ex_rd_addr = 5'd5; ex_rd_enable = 1'b1;
    @(negedge clk);
    check("rst none data",  mem_rd_data, 32'h1234);
    check("rst none rd",    32'(mem_rd_addr), 32'd5);
    check("rst none en",    32'(mem_rd_enable), 32'd1);
    check("rst none stall", 32'(mem_stall), 32'd0);
    check("rst none req",   32'(mc_req), 32'd0);

    // Undefined op code behaves as NONE
    @(posedge clk); #1;
    ex_mem_op = 4'd12; ex_rd_data = 32'h7777;
    @(negedge clk);
    check("op12 req",  32'(mc_req), 32'd0);
    check("op12 data", mem_rd_data, 32'h7777);
    check("op12 en",   32'(mem_rd_enable), 32'd1);
    @(posedge clk); #1;
    ex_mem_op = 4'd0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // rdy low while BUSY, including a lost mc_done, then freeze in DONE
    @(posedge clk); #1;
    ex_mem_op = 4'd3; ex_mem_addr = 32'h40; ex_rd_data = 32'h11; ex_rd_addr = 5'd9;
    @(negedge clk);
    check("rdy c0 stall", 32'(mem_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rdy = 1'b0;
      mc_done = (i == 1); mc_rdata = 32'h0BADF00D;
      @(negedge clk);
      check($sformatf("rdy low%0d stall", i), 32'(mem_stall), 32'd1);
      check($sformatf("rdy low%0d req", i),   32'(mc_req), 32'd1);
    end
    @(posedge clk); #1;
    rdy = 1'b1; mc_done = 1'b1; mc_rdata = 32'h12345678;
    @(negedge clk);
    check("rdy resume stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    mc_done = 1'b0; mc_rdata = 32'h0; rdy = 1'b0;
    @(negedge clk);
    check("rdy done stall", 32'(mem_stall), 32'd0);
    check("rdy done data",  mem_rd_data, 32'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    check("rdy frozen done req",  32'(mc_req), 32'd0);
    check("rdy frozen done data", mem_rd_data, 32'h12345678);
    @(posedge clk); #1;
    rdy = 1'b1;
    @(negedge clk);
    check("rdy done again data", mem_rd_data, 32'h12345678);
    @(posedge clk); #1;
    ex_mem_op = 4'd0; ex_rd_data = 32'h22;
    @(negedge clk);
    check("rdy idle req",  32'(mc_req), 32'd0);
    check("rdy idle data", mem_rd_data, 32'h22);

    // Reset mid-access, then a late mc_done in IDLE
    @(posedge clk); #1;
    ex_mem_op = 4'd2; ex_mem_addr = 32'h80; ex_rd_data = 32'h33; ex_rd_addr = 5'd3;
    @(negedge clk);
    check("rst c0 stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst busy req", 32'(mc_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; ex_mem_op = 4'd0; ex_rd_data = 32'h44;
    mc_done = 1'b1; mc_rdata = 32'h0000FFFF;
    @(negedge clk);
    check("post rst req",   32'(mc_req), 32'd0);
    check("post rst stall", 32'(mem_stall), 32'd0);
    check("post rst data",  mem_rd_data, 32'h44);
    check("post rst en",    32'(mem_rd_enable), 32'd1);
    @(posedge clk); #1;
    mc_done = 1'b0;
    @(negedge clk);
    check("late done stall", 32'(mem_stall), 32'd0);
    check("late done en",    32'(mem_rd_enable), 32'd1);
    check("late done data",  mem_rd_data, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
